// File: rtl/serv_bus_arbiter_pkg.sv
// Shared definitions for the SERV ibus/dbus arbiter: state encoding and grant identifiers.
package serv_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_e;

    localparam logic GRANT_IBUS = 1'b0;
    localparam logic GRANT_DBUS = 1'b1;

    // Round-robin choice when both requesters are up: favour whoever was not served last.
    function automatic arb_state_e arb_pick(input logic ibus_cyc, input logic dbus_cyc,
                                            input logic last_grant);
        arb_state_e pick;
        pick = ARB_IDLE;
        if (ibus_cyc && dbus_cyc)
            pick = (last_grant == GRANT_IBUS) ? ARB_DBUS : ARB_IBUS;
        else if (ibus_cyc)
            pick = ARB_IBUS;
        else if (dbus_cyc)
            pick = ARB_DBUS;
        return pick;
    endfunction

endpackage

// File: rtl/serv_bus_arbiter_wdog.sv
// Watchdog counter for the arbiter: counts wait cycles of an open memory cycle, flags expiry.
module serv_arb_wdog #(
    parameter int TO_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    // Expiry only counts while enabled, so an ack in the last cycle wins over the timeout.
    assign expire = en && (cnt == {TO_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone-classic memory port between SERV ibus and dbus with round-robin
// grant and a watchdog that terminates hung cycles.
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int TO_W = 5
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    arb_state_e state, state_nxt;
    logic       last_grant;
    logic       wb_cyc_q;
    logic       busy;
    logic       wd_en;
    logic       wd_expire;

    assign busy  = (state != ARB_IDLE);
    assign wd_en = busy && !i_wb_ack;

    serv_arb_wdog #(.TO_W(TO_W)) u_wdog (
        .clk    (clk),
        .rst_n  (i_rst_n),
        .clr    (!busy),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // State, grant and cycle registers; last_grant doubles as the registered mux select.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_IBUS;
            wb_cyc_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_cyc_q <= (state_nxt != ARB_IDLE);
            if (state == ARB_IDLE && state_nxt != ARB_IDLE)
                last_grant <= (state_nxt == ARB_DBUS) ? GRANT_DBUS : GRANT_IBUS;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:           state_nxt = arb_pick(i_ibus_cyc, i_dbus_cyc, last_grant);
            ARB_IBUS, ARB_DBUS: if (i_wb_ack || wd_expire) state_nxt = ARB_IDLE;
            default:            state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc   = wb_cyc_q;
        o_timeout  = busy && wd_expire;
        o_ibus_ack = (state == ARB_IBUS) && (i_wb_ack || wd_expire);
        o_dbus_ack = (state == ARB_DBUS) && (i_wb_ack || wd_expire);
        // A watchdog-terminated cycle returns zero instead of whatever is on the memory bus.
        o_ibus_rdt = wd_expire ? 32'h0 : i_wb_rdt;
        o_dbus_rdt = wd_expire ? 32'h0 : i_wb_rdt;
        if (last_grant == GRANT_DBUS) begin
            o_wb_adr = i_dbus_adr;
            o_wb_dat = i_dbus_dat;
            o_wb_sel = i_dbus_sel;
            o_wb_we  = i_dbus_we;
        end else begin
            o_wb_adr = i_ibus_adr;
            o_wb_dat = i_dbus_dat;
            o_wb_sel = 4'hf;
            o_wb_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Randomized self-checking bench for serv_bus_arbiter against a transaction-level model.
module tb_serv_bus_arbiter;

    localparam int TO_MAX = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat, wb_rdt;
    logic        ibus_cyc, dbus_cyc, dbus_we, wb_ack;
    logic [3:0]  dbus_sel;
    logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
    logic        o_ibus_ack, o_dbus_ack, o_wb_we, o_wb_cyc, o_timeout;
    logic [3:0]  o_wb_sel;

    serv_bus_arbiter #(.TO_W(5)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_cyc(o_wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    // Model: which bus owns memory (0 none, 1 ibus, 2 dbus), wait cycles elapsed, last served.
    int m_g, m_w, m_last;
    // Stimulus controls
    int mem_mode;      // 0 random, 1 fixed latency, 2 never ack, 3 ack exactly at expiry
    int mem_lat;
    bit i_auto, d_auto, i_hold, d_hold, force_store, rdt_fixed, stray_ack;
    bit saw_iack, saw_dack, prev_cyc;
    int n_to_seen;
    bit gseq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit busy, exp_to, e_iack, e_dack;
        busy   = (m_g != 0);
        exp_to = busy && (m_w == TO_MAX) && !wb_ack;
        e_iack = (m_g == 1) && (wb_ack || exp_to);
        e_dack = (m_g == 2) && (wb_ack || exp_to);
        chk("wb_cyc",   {31'b0, o_wb_cyc},   {31'b0, busy});
        chk("ibus_ack", {31'b0, o_ibus_ack}, {31'b0, e_iack});
        chk("dbus_ack", {31'b0, o_dbus_ack}, {31'b0, e_dack});
        chk("timeout",  {31'b0, o_timeout},  {31'b0, exp_to});
        if (m_g == 1) begin
            chk("i_adr", o_wb_adr, ibus_adr);
            chk("i_sel", {28'b0, o_wb_sel}, 32'hf);
            chk("i_we",  {31'b0, o_wb_we}, 32'h0);
        end
        if (m_g == 2) begin
            chk("d_adr", o_wb_adr, dbus_adr);
            chk("d_dat", o_wb_dat, dbus_dat);
            chk("d_sel", {28'b0, o_wb_sel}, {28'b0, dbus_sel});
            chk("d_we",  {31'b0, o_wb_we}, {31'b0, dbus_we});
        end
        if (e_iack) chk("i_rdt", o_ibus_rdt, exp_to ? 32'h0 : wb_rdt);
        if (e_dack) chk("d_rdt", o_dbus_rdt, exp_to ? 32'h0 : wb_rdt);
        saw_iack = o_ibus_ack;
        saw_dack = o_dbus_ack;
        if (o_timeout) n_to_seen++;
        if (o_wb_cyc && !prev_cyc) gseq.push_back(o_wb_we);
        prev_cyc = o_wb_cyc;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_g = 0; m_w = 0; m_last = 1;
        end else if (m_g == 0) begin
            if (ibus_cyc && dbus_cyc) m_g = (m_last == 1) ? 2 : 1;
            else if (ibus_cyc)        m_g = 1;
            else if (dbus_cyc)        m_g = 2;
            if (m_g != 0) begin m_last = m_g; m_w = 0; end
        end else if (wb_ack || m_w == TO_MAX) begin
            m_g = 0;
        end else begin
            m_w++;
        end
    endtask

    task automatic new_ireq();
        ibus_cyc = 1'b1;
        ibus_adr = $urandom & 32'h7fff_fffc;
    endtask

    task automatic new_dreq();
        dbus_cyc = 1'b1;
        dbus_adr = $urandom;
        dbus_dat = $urandom;
        dbus_sel = 4'($urandom_range(1, 15));
        dbus_we  = force_store ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic drive_next();
        if (ibus_cyc && saw_iack) begin
            if (i_hold) new_ireq(); else ibus_cyc = 1'b0;
        end else if (!ibus_cyc && i_auto && $urandom_range(0, 3) == 0) new_ireq();
        if (dbus_cyc && saw_dack) begin
            if (d_hold) new_dreq(); else dbus_cyc = 1'b0;
        end else if (!dbus_cyc && d_auto && $urandom_range(0, 3) == 0) new_dreq();
        wb_rdt = rdt_fixed ? 32'hDEADBEEF : $urandom;
        case (mem_mode)
            1:       wb_ack = (m_g != 0) && (m_w == mem_lat);
            2:       wb_ack = 1'b0;
            3:       wb_ack = (m_g != 0) && (m_w == TO_MAX);
            default: wb_ack = (m_g != 0) ? ($urandom_range(0, 2) == 0)
                                         : (stray_ack && $urandom_range(0, 7) == 0);
        endcase
    endtask

    // Called just after a negedge with inputs settled for the coming posedge.
    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        drive_next();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_to_seen = 0;
        gseq.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; ibus_adr = '0; ibus_cyc = 1'b0; dbus_adr = '0; dbus_dat = '0;
        dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0; wb_rdt = '0; wb_ack = 1'b0;
        mem_mode = 1; mem_lat = 3; i_auto = 0; d_auto = 0; i_hold = 0; d_hold = 0;
        force_store = 0; rdt_fixed = 0; stray_ack = 0; prev_cyc = 0; n_to_seen = 0;
        saw_iack = 0; saw_dack = 0;
        repeat (3) @(posedge clk);
        m_g = 0; m_w = 0; m_last = 1;
        @(negedge clk);
        do_reset();

        // 1: ibus only, memory answers after 3 wait cycles with DEADBEEF
        rdt_fixed = 1; mem_mode = 1; mem_lat = 3;
        ibus_cyc = 1'b1; ibus_adr = 32'h100;
        run(10);
        rdt_fixed = 0;

        // 2: both requesting from reset, dbus store wins first
        do_reset();
        ibus_cyc = 1'b1; ibus_adr = 32'h40;
        dbus_cyc = 1'b1; dbus_adr = 32'h2000; dbus_dat = 32'h55AA; dbus_sel = 4'h3; dbus_we = 1'b1;
        mem_lat = 2;
        run(14);
        chk("t2_len", gseq.size(), 2);
        if (gseq.size() >= 2) begin
            chk("t2_g0", {31'b0, gseq[0]}, 32'd1);
            chk("t2_g1", {31'b0, gseq[1]}, 32'd0);
        end

        // 3: both hold cyc, grants must alternate D,I,D,I
        do_reset();
        force_store = 1; i_hold = 1; d_hold = 1; mem_lat = 1;
        new_ireq(); new_dreq();
        for (int b = 0; b < 100 && gseq.size() < 4; b++) cycle();
        chk("t3_len", {31'b0, gseq.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < gseq.size(); i++)
            chk("t3_alt", {31'b0, gseq[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
        i_hold = 0; d_hold = 0; force_store = 0;

        // 4: memory never acks, watchdog terminates the dbus load
        do_reset();
        mem_mode = 2;
        new_dreq(); dbus_we = 1'b0;
        run(40);
        chk("t4_to", n_to_seen, 1);

        // 5: ack lands exactly in the expiry cycle
        do_reset();
        mem_mode = 3;
        new_dreq();
        run(40);
        chk("t5_to", n_to_seen, 0);

        // 6: reset while dbus is waiting, then a pending ibus request gets the bus
        do_reset();
        mem_mode = 2;
        new_dreq();
        run(10);
        ibus_cyc = 1'b1; ibus_adr = 32'h300;
        rst_n = 1'b0;
        cycle();
        chk("t6_cyc", {31'b0, o_wb_cyc}, 32'd0);
        rst_n = 1'b1; dbus_cyc = 1'b0; mem_mode = 1; mem_lat = 2;
        gseq.delete();
        run(8);
        chk("t6_len", {31'b0, gseq.size() >= 1}, 32'd1);
        if (gseq.size() >= 1) chk("t6_ibus", {31'b0, gseq[0]}, 32'd0);

        // Random traffic with stray idle acks and occasional resets
        do_reset();
        mem_mode = 0; i_auto = 1; d_auto = 1; stray_ack = 1;
        for (int i = 0; i < 4000; i++) begin
            i_hold = ($urandom_range(0, 3) == 0);
            d_hold = ($urandom_range(0, 3) == 0);
            if (i % 500 == 250) mem_mode = 2;
            if (i % 500 == 300) mem_mode = 0;
            rst_n = ($urandom_range(0, 599) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
